sc_receiver: RTL and testbench



---
 rtl/sc_pkg.sv | 36 +++
 rtl/sc_field_unpack.sv | 33 +++
 rtl/sc_receiver.sv | 146 ++++++++++++++
 tb/tb_sc_receiver.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sc_pkg
//  Purpose  : Shared constants and types for the slow-control receive side:
//             frame length, field offsets of the transmitter frame map and the
//             receiver FSM state type.
//  Revision : 1.0  initial release
// ============================================================================
package sc_pkg;

  // Number of bits in one slow-control frame
  localparam int SC_FRAME_BITS = 829;

  // Field offsets (inclusive bit ranges) of the transmitter frame map
  localparam int SC_DAC2_LO    = 3;
  localparam int SC_DAC2_HI    = 12;
  localparam int SC_DAC1_LO    = 13;
  localparam int SC_DAC1_HI    = 22;
  localparam int SC_MASK_OR_LO = 27;
  localparam int SC_MASK_OR_HI = 154;
  localparam int SC_GLOBAL_LO  = 155;
  localparam int SC_GLOBAL_HI  = 188;
  localparam int SC_GAIN_LO    = 189;
  localparam int SC_GAIN_HI    = 764;
  localparam int SC_CTEST_LO   = 765;
  localparam int SC_CTEST_HI   = 828;

  // Receiver FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } sc_state_t;

endpackage
`default_nettype wire

// File: rtl/sc_field_unpack.sv
`default_nettype none
// ============================================================================
//  Module   : sc_field_unpack
//  Purpose  : Purely combinational slicer that splits a received slow-control
//             frame into its named configuration fields. The unnamed gaps of
//             the frame map are exposed as head/spare so no bit is dropped.
//  Revision : 1.0  initial release
// ============================================================================
module sc_field_unpack
  import sc_pkg::*;
(
  input  logic [SC_FRAME_BITS-1:0]                 frame,
  output logic [SC_DAC2_LO-1:0]                    head,
  output logic [SC_DAC2_HI-SC_DAC2_LO:0]           dac2,
  output logic [SC_DAC1_HI-SC_DAC1_LO:0]           dac1,
  output logic [SC_MASK_OR_LO-SC_DAC1_HI-2:0]      spare,
  output logic [SC_MASK_OR_HI-SC_MASK_OR_LO:0]     mask_or,
  output logic [SC_GLOBAL_HI-SC_GLOBAL_LO:0]       glb,
  output logic [SC_GAIN_HI-SC_GAIN_LO:0]           gain,
  output logic [SC_CTEST_HI-SC_CTEST_LO:0]         ctest
);

  assign head    = frame[SC_DAC2_LO-1:0];
  assign dac2    = frame[SC_DAC2_HI:SC_DAC2_LO];
  assign dac1    = frame[SC_DAC1_HI:SC_DAC1_LO];
  assign spare   = frame[SC_MASK_OR_LO-1:SC_DAC1_HI+1];
  assign mask_or = frame[SC_MASK_OR_HI:SC_MASK_OR_LO];
  assign glb     = frame[SC_GLOBAL_HI:SC_GLOBAL_LO];
  assign gain    = frame[SC_GAIN_HI:SC_GAIN_LO];
  assign ctest   = frame[SC_CTEST_HI:SC_CTEST_LO];

endmodule
`default_nettype wire

// File: rtl/sc_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : sc_receiver
//  Purpose  : Deserializes an LSB-first slow-control frame into a parallel
//             word, holds it until the host acknowledges it, and compares the
//             held frame against a host-supplied expected frame.
//  Revision : 1.0  initial release
// ============================================================================
module sc_receiver
  import sc_pkg::*;
#(
  parameter int FRAME_BITS = SC_FRAME_BITS,
  parameter int CNT_W      = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rstn_sc,
  input  logic                  sc_en,
  input  logic                  sc_d,
  input  logic                  frame_ack,
  input  logic [FRAME_BITS-1:0] exp_frame,
  output logic [FRAME_BITS-1:0] frame,
  output logic                  frame_valid,
  output logic                  match,
  output logic                  busy,
  output logic [CNT_W-1:0]      bit_cnt,
  output logic                  overflow
);

  // Count value reached when the last bit of a frame has been accepted
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  // A one-bit frame is complete as soon as its first bit arrives
  localparam sc_state_t FIRST_BIT_STATE = (FRAME_BITS == 1) ? ST_HOLD : ST_SHIFT;

  sc_state_t             state;
  sc_state_t             state_nxt;
  logic [FRAME_BITS-1:0] sr;
  logic [FRAME_BITS-1:0] sr_shifted;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_nxt;
  logic                  ovf;
  logic                  ovf_nxt;
  logic                  take_bit;
  logic                  clear_sr;

  // New bits enter at the MSB and the register moves right, so after a full
  // frame the first bit received sits at bit 0.
  generate
    if (FRAME_BITS == 1) begin : g_single_bit
      assign sr_shifted = sc_d;
    end else begin : g_multi_bit
      assign sr_shifted = {sc_d, sr[FRAME_BITS-1:1]};
    end
  endgenerate

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, counter and control decode; a link frame reset overrides all
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf;
    take_bit  = 1'b0;
    clear_sr  = 1'b0;
    if (!rstn_sc) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      ovf_nxt   = 1'b0;
      clear_sr  = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sc_en) begin
            take_bit  = 1'b1;
            cnt_nxt   = ONE_CNT;
            state_nxt = FIRST_BIT_STATE;
          end
        end
        ST_SHIFT: begin
          if (sc_en) begin
            take_bit = 1'b1;
            cnt_nxt  = cnt + ONE_CNT;
            if (cnt == FULL_CNT - ONE_CNT) begin
              state_nxt = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (frame_ack) begin
            if (sc_en) begin
              // The coincident bit opens the next frame
              take_bit  = 1'b1;
              cnt_nxt   = ONE_CNT;
              state_nxt = FIRST_BIT_STATE;
            end else begin
              cnt_nxt   = '0;
              state_nxt = ST_IDLE;
            end
          end else if (sc_en) begin
            // No room: the held frame stays frozen and the bit is lost
            ovf_nxt = 1'b1;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Datapath registers: shift register, bit counter and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      sr  <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      ovf <= ovf_nxt;
      if (clear_sr) begin
        sr <= '0;
      end else if (take_bit) begin
        sr <= sr_shifted;
      end
    end
  end

  assign frame       = sr;
  assign frame_valid = (state == ST_HOLD);
  assign busy        = (state == ST_SHIFT);
  assign bit_cnt     = cnt;
  assign overflow    = ovf;
  assign match       = frame_valid && (sr == exp_frame);

endmodule
`default_nettype wire

// File: tb/tb_sc_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sc_receiver
//  Purpose  : Self-checking bench for sc_receiver: directed frames with a
//             position-indexed reference model compared every cycle, plus
//             hand-computed checks at the interesting boundaries.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sc_receiver;
  import sc_pkg::*;

  localparam int FB = SC_FRAME_BITS;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rstn_sc = 1'b1;
  logic          sc_en = 1'b0;
  logic          sc_d = 1'b0;
  logic          frame_ack = 1'b0;
  logic [FB-1:0] exp_frame = '0;
  logic [FB-1:0] frame;
  logic          frame_valid;
  logic          match;
  logic          busy;
  logic [CW-1:0] bit_cnt;
  logic          overflow;

  logic [2:0]   u_head;
  logic [9:0]   u_dac2;
  logic [9:0]   u_dac1;
  logic [3:0]   u_spare;
  logic [127:0] u_mask_or;
  logic [33:0]  u_glb;
  logic [575:0] u_gain;
  logic [63:0]  u_ctest;

  int total = 0;
  int bad   = 0;

  // Reference model state: bits are stored by arrival index, not shifted
  logic [FB-1:0] m_acc   = '0;
  logic [FB-1:0] m_frame = '0;
  int            m_cnt   = 0;
  bit            m_hold  = 1'b0;
  bit            m_busy  = 1'b0;
  bit            m_ovf   = 1'b0;
  bit            m_known = 1'b1;

  logic [FB-1:0] f1, f2, f3, f4, f5, f6;

  always #5 clk = ~clk;

  sc_receiver #(.FRAME_BITS(FB), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .rstn_sc     (rstn_sc),
    .sc_en       (sc_en),
    .sc_d        (sc_d),
    .frame_ack   (frame_ack),
    .exp_frame   (exp_frame),
    .frame       (frame),
    .frame_valid (frame_valid),
    .match       (match),
    .busy        (busy),
    .bit_cnt     (bit_cnt),
    .overflow    (overflow)
  );

  sc_field_unpack u_unpack (
    .frame   (frame),
    .head    (u_head),
    .dac2    (u_dac2),
    .dac1    (u_dac1),
    .spare   (u_spare),
    .mask_or (u_mask_or),
    .glb     (u_glb),
    .gain    (u_gain),
    .ctest   (u_ctest)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkf(input string nm, input logic [FB-1:0] act, input logic [FB-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge from the inputs sampled at that edge
  task automatic model_step();
    if (rst || !rstn_sc) begin
      m_cnt = 0; m_hold = 0; m_busy = 0; m_frame = '0; m_known = 1;
      m_ovf = 0;
    end else if (m_hold) begin
      if (frame_ack) begin
        m_hold  = 0;
        m_known = 0;
        if (sc_en) begin
          m_acc    = '0;
          m_acc[0] = sc_d;
          m_cnt    = 1;
          m_busy   = 1;
        end else begin
          m_cnt = 0;
        end
      end else if (sc_en) begin
        m_ovf = 1;
      end
    end else if (sc_en) begin
      if (m_cnt == 0) m_acc = '0;
      m_acc[m_cnt] = sc_d;
      m_cnt++;
      m_busy  = 1;
      m_known = 0;
      if (m_cnt == FB) begin
        m_hold  = 1;
        m_busy  = 0;
        m_frame = m_acc;
        m_known = 1;
      end
    end
  endtask

  // Per-cycle comparison of every output against the model
  initial begin : compare_proc
    forever begin
      @(posedge clk);
      model_step();
      #1;
      chk("bit_cnt", 64'(bit_cnt), 64'(m_cnt));
      chk("frame_valid", 64'(frame_valid), 64'(m_hold));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("match", 64'(match), 64'(m_hold && (m_frame == exp_frame)));
      if (m_known) chkf("frame", frame, m_frame);
    end
  end

  // One input cycle: values change 2 time units after the edge
  task automatic drive(input logic en, input logic d, input logic ack,
                       input logic rs, input logic rn);
    @(posedge clk);
    #2;
    sc_en = en; sc_d = d; frame_ack = ack; rst = rs; rstn_sc = rn;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic send_bits(input logic [FB-1:0] f, input int lo, input int hi,
                           input int gap);
    for (int i = lo; i <= hi; i++) begin
      drive(1'b1, f[i], 1'b0, 1'b0, 1'b1);
      if (gap > 0 && (i % gap) == gap - 1 && i != hi) idle();
    end
  endtask

  task automatic rand_frame(output logic [FB-1:0] f);
    for (int i = 0; i < FB; i++) f[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic chk_reset(input string tag);
    chkf({tag, "_frame"}, frame, '0);
    chk({tag, "_valid"}, 64'(frame_valid), 64'd0);
    chk({tag, "_match"}, 64'(match), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_cnt"}, 64'(bit_cnt), 64'd0);
    chk({tag, "_ovf"}, 64'(overflow), 64'd0);
  endtask

  initial begin : stim
    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle();
    chk_reset("rst");

    // Single marker bit at position 0, back-to-back strobes
    f1 = '0;
    f1[0] = 1'b1;
    send_bits(f1, 0, FB - 2, 0);
    drive(1'b1, f1[FB-1], 1'b0, 1'b0, 1'b1);
    chk("pre_last_valid", 64'(frame_valid), 64'd0);
    chk("pre_last_cnt", 64'(bit_cnt), 64'd828);
    idle();
    chk("single_valid", 64'(frame_valid), 64'd1);
    chk("single_cnt", 64'(bit_cnt), 64'd829);
    chk("single_bit0", 64'(frame[0]), 64'd1);
    chk("single_rest", 64'(frame[FB-1:1] == '0), 64'd1);
    chk("single_match_vs_zero", 64'(match), 64'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle();
    chk("ack_valid", 64'(frame_valid), 64'd0);
    chk("ack_cnt", 64'(bit_cnt), 64'd0);

    // Loopback-style frame with DAC1 = 2A5, gaps every 97 bits
    rand_frame(f2);
    f2[22:13] = 10'h2A5;
    exp_frame = f2;
    send_bits(f2, 0, FB - 1, 97);
    idle();
    chk("loop_match", 64'(match), 64'd1);
    chk("unp_dac1", 64'(u_dac1), 64'h2A5);
    chk("unp_dac2", 64'(u_dac2), 64'(f2[12:3]));
    chk("unp_head", 64'(u_head), 64'(f2[2:0]));
    chk("unp_spare", 64'(u_spare), 64'(f2[26:23]));
    chk("unp_glb", 64'(u_glb), 64'(f2[188:155]));
    chk("unp_ctest", u_ctest, f2[828:765]);
    chkf("unp_mask_or", FB'(u_mask_or), FB'(f2[154:27]));
    chkf("unp_gain", FB'(u_gain), FB'(f2[764:189]));
    exp_frame[500] = ~exp_frame[500];
    #1;
    chk("loop_mismatch", 64'(match), 64'd0);
    exp_frame = f2;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle();

    // Abort after 400 bits, coincident strobe is dropped
    rand_frame(f3);
    send_bits(f3, 0, 399, 0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    chk("abort_cnt", 64'(bit_cnt), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chkf("abort_frame", frame, '0);
    rand_frame(f4);
    exp_frame = f4;
    send_bits(f4, 0, FB - 1, 0);
    idle();
    chkf("after_abort_frame", frame, f4);
    chk("after_abort_match", 64'(match), 64'd1);

    // Overflow: three strobes while held, then cleared by link reset
    repeat (3) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    idle();
    chk("ovf_set", 64'(overflow), 64'd1);
    chkf("ovf_frame", frame, f4);
    chk("ovf_cnt", 64'(bit_cnt), 64'd829);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    chk("ovf_clr", 64'(overflow), 64'd0);
    chk("ovf_clr_valid", 64'(frame_valid), 64'd0);

    // Ack and bit in the same cycle start the next frame
    rand_frame(f5);
    send_bits(f5, 0, FB - 1, 0);
    idle();
    rand_frame(f6);
    f6[0] = 1'b1;
    exp_frame = f6;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    idle();
    chk("ackbit_busy", 64'(busy), 64'd1);
    chk("ackbit_cnt", 64'(bit_cnt), 64'd1);
    chk("ackbit_valid", 64'(frame_valid), 64'd0);
    send_bits(f6, 1, FB - 1, 0);
    idle();
    chkf("ackbit_frame", frame, f6);
    chk("ackbit_bit0", 64'(frame[0]), 64'd1);
    chk("ackbit_match", 64'(match), 64'd1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle();

    // Synchronous reset mid-frame, alone and together with link reset
    send_bits(f5, 0, 599, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle();
    chk_reset("midrst");
    send_bits(f5, 0, 599, 0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle();
    chk_reset("midrst_rstn");
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
